// File: rtl/dtc_pkg.sv
// Shared types and sizing helpers for the sequential decision-tree engine.
// Node word layout, MSB first: {is_leaf, feat, hi_ptr, lo_ptr}.
package dtc_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DTC_N_FEAT    = 8;
  localparam int DTC_CLASS_W   = 2;
  localparam int DTC_N_NODES   = 32;
  localparam int DTC_MAX_DEPTH = 16;
  localparam int DTC_AW        = clog2_min1(DTC_N_NODES);
  localparam int DTC_FW        = clog2_min1(DTC_N_FEAT);

  typedef struct packed {
    logic              is_leaf;
    logic [DTC_FW-1:0] feat;
    logic [DTC_AW-1:0] hi_ptr;
    logic [DTC_AW-1:0] lo_ptr;
  } node_t;

  // Field offsets within a node word for arbitrary AW/FW.
  function automatic int node_w(input int aw, input int fw);
    return 1 + fw + 2 * aw;
  endfunction
  function automatic int hi_off(input int aw);
    return aw;
  endfunction
  function automatic int feat_off(input int aw);
    return 2 * aw;
  endfunction
  function automatic int leaf_off(input int aw, input int fw);
    return 2 * aw + fw;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dtc_node_table.sv
// Register-array node table: resets every entry to leaf class 0, one write
// port, and two asynchronous read ports (tree walk and config readback).
module dtc_node_table
  import dtc_pkg::*;
#(
  parameter int N_NODES = 32,
  parameter int AW      = 5,
  parameter int WW      = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic [AW-1:0] walk_addr_i,
  output logic [WW-1:0] walk_data_o,
  input  logic [AW-1:0] rb_addr_i,
  output logic [WW-1:0] rb_data_o
);

  localparam logic [WW-1:0] LEAF0 = {1'b1, {(WW-1){1'b0}}};

  logic [WW-1:0] mem_q [N_NODES];
  logic          walk_ok;
  logic          rb_ok;
  logic          wr_ok;

  // Addresses past the last entry only exist when N_NODES is not a power of 2.
  generate
    if (N_NODES == (1 << AW)) begin : g_full
      assign walk_ok = 1'b1;
      assign rb_ok   = 1'b1;
      assign wr_ok   = 1'b1;
    end else begin : g_part
      assign walk_ok = (32'(walk_addr_i) < N_NODES);
      assign rb_ok   = (32'(rb_addr_i) < N_NODES);
      assign wr_ok   = (32'(waddr_i) < N_NODES);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) begin
        mem_q[i] <= LEAF0;
      end
    end else if (we_i && wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign walk_data_o = walk_ok ? mem_q[walk_addr_i] : LEAF0;
  assign rb_data_o   = rb_ok   ? mem_q[rb_addr_i]   : LEAF0;

endmodule

// File: rtl/dtc_seq_engine.sv
// Sequential decision-tree classifier: walks one node of a run-time loaded
// table per cycle, from root node 0 until a leaf or the depth limit.
module dtc_seq_engine
  import dtc_pkg::*;
#(
  parameter int N_FEAT    = DTC_N_FEAT,
  parameter int CLASS_W   = DTC_CLASS_W,
  parameter int N_NODES   = DTC_N_NODES,
  parameter int MAX_DEPTH = DTC_MAX_DEPTH,
  localparam int AW       = clog2_min1(N_NODES),
  localparam int FW       = clog2_min1(N_FEAT),
  localparam int WW       = node_w(AW, FW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [N_FEAT-1:0]  in_feat_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CLASS_W-1:0] out_class_o,
  output logic               out_err_o,
  input  logic               cfg_we_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [WW-1:0]      cfg_wdata_i,
  output logic [WW-1:0]      cfg_rdata_o,
  output logic               cfg_err_o,
  output state_e             dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid and its payload hold until that edge, ready may toggle freely.

  localparam int SW       = $clog2(MAX_DEPTH) + 1;
  localparam int HI_OFF   = hi_off(AW);
  localparam int FEAT_OFF = feat_off(AW);
  localparam int LEAF_OFF = leaf_off(AW, FW);

  state_e             state_q, state_d;
  logic [AW-1:0]      cur_q, cur_d;
  logic [SW-1:0]      step_q, step_d;
  logic [N_FEAT-1:0]  feat_q, feat_d;
  logic [CLASS_W-1:0] cls_q, cls_d;
  logic               err_q, err_d;
  logic               cfg_err_q;

  logic [WW-1:0]      node_word;
  logic               node_leaf;
  logic [FW-1:0]      node_feat;
  logic [AW-1:0]      node_hi;
  logic [AW-1:0]      node_lo;
  logic [(1<<FW)-1:0] feat_pad;
  logic               branch_bit;
  logic               accept;
  logic               table_we;

  assign in_ready_o = rst_n && (state_q == ST_IDLE);
  assign accept     = in_valid_i && in_ready_o;
  assign table_we   = cfg_we_i && (state_q == ST_IDLE);

  dtc_node_table #(
    .N_NODES (N_NODES),
    .AW      (AW),
    .WW      (WW)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (table_we),
    .waddr_i     (cfg_addr_i),
    .wdata_i     (cfg_wdata_i),
    .walk_addr_i (cur_q),
    .walk_data_o (node_word),
    .rb_addr_i   (cfg_addr_i),
    .rb_data_o   (cfg_rdata_o)
  );

  assign node_leaf = node_word[LEAF_OFF];
  assign node_feat = node_word[FEAT_OFF +: FW];
  assign node_hi   = node_word[HI_OFF +: AW];
  assign node_lo   = node_word[0 +: AW];

  // Feature indices beyond N_FEAT land in the zero padding.
  always_comb begin
    feat_pad = '0;
    feat_pad[N_FEAT-1:0] = feat_q;
  end
  assign branch_bit = feat_pad[node_feat];

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    step_d  = step_q;
    feat_d  = feat_q;
    cls_d   = cls_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          feat_d  = in_feat_i;
          cur_d   = '0;
          step_d  = '0;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (node_leaf) begin
          cls_d   = node_lo[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (step_q == SW'(MAX_DEPTH - 1)) begin
          cls_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cur_d  = branch_bit ? node_hi : node_lo;
          step_d = step_q + SW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      step_q    <= '0;
      feat_q    <= '0;
      cls_q     <= '0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      step_q    <= step_d;
      feat_q    <= feat_d;
      cls_q     <= cls_d;
      err_q     <= err_d;
      cfg_err_q <= cfg_we_i && (state_q != ST_IDLE);
    end
  end

  assign out_valid_o = (state_q == ST_DONE);
  assign out_class_o = cls_q;
  assign out_err_o   = err_q;
  assign cfg_err_o   = cfg_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dtc_seq_engine.sv
// Self-checking bench for dtc_seq_engine: directed table scenarios plus random
// tables, checked against a behavioural tree-walk model through a scoreboard.
module tb_dtc_seq_engine;
  import dtc_pkg::*;

  localparam int N_FEAT    = 8;
  localparam int N_NODES   = 32;
  localparam int MAX_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_feat = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_class;
  logic        out_err;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [13:0] cfg_wdata = '0;
  logic [13:0] cfg_rdata;
  logic        cfg_err;
  state_e      dbg_state;

  dtc_seq_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_feat_i   (in_feat),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_class_o (out_class),
    .out_err_o   (out_err),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .cfg_err_o   (cfg_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [10:0] exp_q[$];  // {latency[7:0], err, class[1:0]}
  int          acc_q[$];  // cycle count at the acceptance edge
  node_t       mdl[N_NODES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic node_t mk_node(input bit leaf, input int f, input int hi, input int lo);
    node_t n;
    n.is_leaf = leaf;
    n.feat    = 3'(f);
    n.hi_ptr  = 5'(hi);
    n.lo_ptr  = 5'(lo);
    return n;
  endfunction

  // Reference: follow the tree from node 0; latency is depth+2, overflow once
  // MAX_DEPTH internal nodes have been visited.
  function automatic logic [10:0] model_walk(input logic [7:0] f);
    int    cur;
    node_t n;
    cur = 0;
    for (int d = 0; d < MAX_DEPTH; d++) begin
      n = mdl[cur];
      if (n.is_leaf) return {8'(d + 2), 1'b0, n.lo_ptr[1:0]};
      if (int'(n.feat) < N_FEAT && f[n.feat]) cur = int'(n.hi_ptr);
      else cur = int'(n.lo_ptr);
    end
    return {8'(MAX_DEPTH + 1), 1'b1, 2'b00};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_NODES; i++) mdl[i] = mk_node(1, 0, 0, 0);
    exp_q.delete();
    acc_q.delete();
  endtask

  // ---------------- monitor ----------------
  bit          seen = 1'b0;
  logic [10:0] cur_exp;
  int          cur_acc;
  logic [1:0]  held_cls;
  logic        held_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      check("in_ready_busy", in_ready, 0);
      if (!seen) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: out_valid=1 class=%0d with empty expected queue", out_class);
        end else begin
          cur_exp = exp_q.pop_front();
          cur_acc = acc_q.pop_front();
          check("out_class", out_class, cur_exp[1:0]);
          check("out_err", out_err, cur_exp[2]);
          check("latency", cyc - cur_acc, cur_exp[10:3]);
        end
        held_cls = out_class;
        held_err = out_err;
        seen = 1'b1;
      end else begin
        check("hold_class", out_class, held_cls);
        check("hold_err", out_err, held_err);
      end
      if (out_ready) seen = 1'b0;
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic send(input logic [7:0] f, input bit wr, input logic [4:0] a, input node_t w);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_feat  = f;
    cfg_we   = wr;
    cfg_addr = a;
    cfg_wdata = w;
    while (!done && t < 100) begin
      @(negedge clk);
      if (in_ready) begin
        if (wr) mdl[a] = w;
        exp_q.push_back(model_walk(f));
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic drain(input int hold);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 100);
    if (!out_valid) begin
      n_checks++;
      $display("FAIL drain_timeout: out_valid=0 required 1");
      @(posedge clk); #1;
      return;
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_out", in_ready, 1);
    check("out_valid_after_out", out_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [4:0] a, input node_t w);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = w;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mdl[a] = w;
    @(negedge clk);
    check("cfg_rdata", cfg_rdata, w);
    check("cfg_err_idle", cfg_err, 0);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [7:0] f, input int hold);
    send(f, 1'b0, 5'd0, mk_node(1, 0, 0, 0));
    drain(hold);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_err", out_err, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_rdata0", cfg_rdata, mk_node(1, 0, 0, 0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // Empty table: root leaf class 0, two cycles.
    run(8'hFF, 0);

    // Small tree.
    cfg_write(5'd0, mk_node(0, 3, 2, 1));
    cfg_write(5'd1, mk_node(1, 0, 0, 0));
    cfg_write(5'd2, mk_node(0, 6, 4, 3));
    cfg_write(5'd3, mk_node(1, 0, 0, 2));
    cfg_write(5'd4, mk_node(1, 0, 0, 1));
    run(8'h08, 0);
    run(8'h48, 1);
    run(8'h00, 0);

    // Stall the output for 5 cycles.
    run(8'h48, 5);

    // Write concurrent with the handshake: the walk sees the new leaf 3.
    send(8'h08, 1'b1, 5'd3, mk_node(1, 0, 0, 3));
    drain(0);
    cfg_addr = 5'd3;
    #1 check("concurrent_wr_rdata", cfg_rdata, mk_node(1, 0, 0, 3));

    // Self-loop -> depth overflow; a write during the walk is rejected.
    cfg_write(5'd0, mk_node(0, 0, 0, 0));
    send(8'h5A, 1'b0, 5'd0, mk_node(1, 0, 0, 0));
    cfg_we = 1'b1;
    cfg_addr = 5'd5;
    cfg_wdata = mk_node(1, 0, 0, 3);
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    check("cfg_rdata_unchanged", cfg_rdata, mdl[5]);
    @(negedge clk);
    check("cfg_err_single", cfg_err, 0);
    @(posedge clk); #1;
    drain(0);

    // Reset for one edge in the middle of a walk.
    send(8'hFF, 1'b0, 5'd0, mk_node(1, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      cfg_addr = 5'(i);
      #1 check("midrst_table", cfg_rdata, mk_node(1, 0, 0, 0));
    end
    @(posedge clk); #1;
    run(8'h3C, 0);

    // Random tables and vectors.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_NODES; i++) begin
        cfg_write(5'(i), mk_node($urandom_range(0, 1), $urandom_range(0, 7),
                                 $urandom_range(0, 31), $urandom_range(0, 31)));
      end
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 3) == 0)
          send(8'($urandom), 1'b1, 5'($urandom_range(0, 31)),
               mk_node($urandom_range(0, 1), $urandom_range(0, 7),
                       $urandom_range(0, 31), $urandom_range(0, 31)));
        else
          send(8'($urandom), 1'b0, 5'd0, mk_node(1, 0, 0, 0));
        drain($urandom_range(0, 2));
      end
    end

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover_expected: %0d results never produced, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dtc_seq_engine.md
Name: dtc_seq_engine

Overview:
- Programmable, sequential decision-tree classifier over binary features.
- Generalises the fixed combinational per-tree classifiers to a run-time loaded node table, parametrised feature, class and tree size.
- Walks one node per cycle, with valid/ready handshakes on the input and output sides.
- Sits between the feature front-end and the class-vote/aggregation stage; the table is loaded through a simple config write port.

Parameters:
- N_FEAT, 8: number of binary input features (width of in_feat).
- CLASS_W, 2: class label width. Must be <= AW.
- N_NODES, 32: node table entries. AW = clog2(N_NODES), FW = clog2(N_FEAT).
- MAX_DEPTH, 16: maximum number of internal nodes visited before the walk aborts.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine can accept a vector.
- in_feat  in  N_FEAT  feature bits.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_class  out  CLASS_W  classified label.
- out_err  out  1  walk aborted (depth overflow); out_class=0.
- cfg_we  in  1  node table write strobe.
- cfg_addr  in  AW  node index.
- cfg_wdata  in  1+FW+2*AW  node word {is_leaf, feat, hi_ptr, lo_ptr}.
- cfg_rdata  out  1+FW+2*AW  combinational readback of table[cfg_addr].
- cfg_err  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset is synchronous: while rst_n=0 at a clk edge, the state goes to IDLE and every table entry becomes leaf class 0 (is_leaf=1, other fields 0).
- Reset values: in_ready=0 during reset and 1 after it, out_valid=0, out_class=0, out_err=0, cfg_err=0.
- Reset mid-walk discards the walk; no output is produced for it.
- A node word with is_leaf=0 branches on in_feat[feat]: bit=1 goes to hi_ptr, bit=0 goes to lo_ptr.
- A node word with is_leaf=1 yields class = lo_ptr[CLASS_W-1:0]. Other fields are ignored.
- A feat value >= N_FEAT reads as bit 0.
- The root is always node 0.
- FSM states: IDLE, WALK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_feat, cur=0, step=0, go to WALK.
- WALK, one table lookup per cycle:
  - Leaf: latch class, out_err=0, go to DONE.
  - Non-leaf with step==MAX_DEPTH-1: out_class=0, out_err=1, go to DONE.
  - Otherwise: cur=child, step=step+1.
  - The step counter is clog2(MAX_DEPTH)+1 bits wide and never wraps.
- DONE:
  - out_valid=1; out_class and out_err are held stable.
  - On out_ready: go to IDLE, out_valid=0.
- Latency: handshake at edge t; a leaf at depth d (root is depth 0) gives out_valid in the cycle after edge t+1+d.
  - Root leaf: 2 cycles after acceptance.
  - Overflow: MAX_DEPTH+1 cycles after acceptance.
- in_ready=0 in WALK and DONE. There is no overlap of vectors.
- Config writes:
  - Accepted only in IDLE, taking effect at that edge.
  - In WALK/DONE the write is dropped and cfg_err pulses for 1 cycle.
  - A write coinciding with an input handshake in IDLE is accepted; the new walk sees the updated table.
- Out-of-range pointers (>= N_NODES, when N_NODES is not a power of 2) are treated as a leaf with class 0.

Decomposition:
- Shared package dtc_pkg holds:
  - the node word typedef {is_leaf, feat, hi_ptr, lo_ptr} with its field offsets;
  - the FSM state enum;
  - the clog2 helpers for AW and FW.
- One sub-module, dtc_node_table: the register-array table with reset-to-leaf behaviour, the write port and two asynchronous read ports (walk and readback).
- The top level holds the FSM, the step counter and the handshake logic.

Test Plan:
- Post-reset, no config writes; in_feat=8'hFF -> out_class=0, out_err=0, out_valid 2 cycles after acceptance.
- Program the following table, then apply in_feat=8'h08 -> class 2 after 4 cycles; in_feat=8'h48 -> class 1 after 4 cycles; in_feat=8'h00 -> class 0 after 3 cycles.
  - node0 = {0, f3, hi=2, lo=1}
  - node1 = leaf 0
  - node2 = {0, f6, hi=4, lo=3}
  - node3 = leaf 2
  - node4 = leaf 1
- Self-loop node0 = {0, f0, 0, 0}; any input -> out_err=1, out_class=0 after MAX_DEPTH+1=17 cycles.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid/out_class stable, in_ready=0; raise out_ready -> in_ready=1 next cycle.
- cfg_we during WALK -> cfg_err pulses once, cfg_rdata unchanged; a write in IDLE concurrent with in_valid -> the walk uses the new entry.
- Assert rst_n=0 for one edge mid-WALK -> next cycle: IDLE, out_valid=0, table back to all leaf-0.
